// File: rtl/ifu_itcm_rsp_pkg.sv
// ---------------------------------------------------------------------------
// ifu_itcm_rsp_pkg
// Shared definitions for the IFU ITCM responder.
//   - Global macros: PC_SIZE, INSTR_SIZE, INSTR_NOP and the ITCM defaults.
//     They are guarded so that an existing project-wide defines file wins.
//   - itcm_state_e: responder FSM state encoding.
// ---------------------------------------------------------------------------
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif
`ifndef ITCM_BASE_DEFAULT
`define ITCM_BASE_DEFAULT 32'h8000_0000
`endif
`ifndef ITCM_ADDR_WIDTH_DEFAULT
`define ITCM_ADDR_WIDTH_DEFAULT 14
`endif

package ifu_itcm_rsp_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;  // nothing outstanding
    localparam logic [1:0] ST_RSP_ENC  = 2'd1;  // SRAM output valid this cycle
    localparam logic [1:0] ST_HOLD_ENC = 2'd2;  // response parked in holding buffer

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RSP  = ST_RSP_ENC,
        ST_HOLD = ST_HOLD_ENC
    } itcm_state_e;

endpackage

// File: rtl/gnrl_dffs.sv
// ---------------------------------------------------------------------------
// General-purpose flop primitives.
//   gnrl_dffr  : asynchronous active-low reset to 0, loads every cycle.
//     dnxt (in, DW), qout (out, DW), clk, rst_n
//   gnrl_dfflr : as gnrl_dffr but loads only when lden is high.
//     lden (in), dnxt (in, DW), qout (out, DW), clk, rst_n
// ---------------------------------------------------------------------------
module gnrl_dffr #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst_n
);
    logic [DW-1:0] qout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout_q <= '0;
        end else begin
            qout_q <= dnxt;
        end
    end

    assign qout = qout_q;
endmodule

module gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst_n
);
    logic [DW-1:0] qout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout_q <= '0;
        end else if (lden) begin
            qout_q <= dnxt;
        end
    end

    assign qout = qout_q;
endmodule

// File: rtl/ifu_itcm_rsp_buf.sv
// ---------------------------------------------------------------------------
// ifu_itcm_rsp_buf
// Single-entry holding buffer for a stalled fetch response (data + err).
//   clk, rst_n   : clock, async active-low reset (buffer resets to 0)
//   load_i       : capture data_i/err_i
//   clear_i      : return the entry to 0 (load_i wins if both are high)
//   data_i/err_i : response to capture
//   data_o/err_o : held response
// ---------------------------------------------------------------------------
module ifu_itcm_rsp_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic [DW-1:0] data_i,
    input  logic          err_i,
    output logic [DW-1:0] data_o,
    output logic          err_o
);
    logic          buf_en;
    logic [DW:0]   buf_d;
    logic [DW:0]   buf_q;

    always_comb begin
        buf_en = load_i | clear_i;
        buf_d  = '0;
        if (load_i) begin
            buf_d = {err_i, data_i};
        end
    end

    gnrl_dfflr #(.DW(DW + 1)) u_buf_dff (
        .lden  (buf_en),
        .dnxt  (buf_d),
        .qout  (buf_q),
        .clk   (clk),
        .rst_n (rst_n)
    );

    assign err_o  = buf_q[DW];
    assign data_o = buf_q[DW-1:0];
endmodule

// File: rtl/ifu_itcm_rsp.sv
// ---------------------------------------------------------------------------
// ifu_itcm_rsp
// IFU fetch responder in front of a single-port synchronous ITCM SRAM with
// 1-cycle read latency. One fetch per cycle sustained, full backpressure on
// the response side, and a loader write port that has priority over fetch.
//
// Handshake rule (all three channels): a transfer happens on a rising edge
// where valid and ready are both high; ready may depend combinationally on
// valid of the other channels, and a presented response holds its payload
// stable until it is taken.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ifu_req_valid/ready/pc          fetch request channel
//   ifu_rsp_valid/ready/instr/err   fetch response channel (err = out of window)
//   ld_valid/ready/addr/wdata       loader write channel (word address)
//   ram_cs/we/addr/wdata, ram_dout  SRAM macro interface
//   dbg_state                       current FSM state (itcm_state_e encoding)
// ---------------------------------------------------------------------------
module ifu_itcm_rsp
    import ifu_itcm_rsp_pkg::*;
#(
    parameter int                   ITCM_ADDR_WIDTH = `ITCM_ADDR_WIDTH_DEFAULT,
    parameter logic [`PC_SIZE-1:0]  ITCM_BASE       = `ITCM_BASE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ifu_req_valid,
    output logic                        ifu_req_ready,
    input  logic [`PC_SIZE-1:0]         ifu_req_pc,
    output logic                        ifu_rsp_valid,
    input  logic                        ifu_rsp_ready,
    output logic [`INSTR_SIZE-1:0]      ifu_rsp_instr,
    output logic                        ifu_rsp_err,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [ITCM_ADDR_WIDTH-3:0]  ld_addr,
    input  logic [`INSTR_SIZE-1:0]      ld_wdata,
    output logic                        ram_cs,
    output logic                        ram_we,
    output logic [ITCM_ADDR_WIDTH-3:0]  ram_addr,
    output logic [`INSTR_SIZE-1:0]      ram_wdata,
    input  logic [`INSTR_SIZE-1:0]      ram_dout,
    output logic [1:0]                  dbg_state
);
    itcm_state_e              state_d;
    itcm_state_e              state_q;
    logic [1:0]               state_raw_q;
    logic                     err_d;
    logic                     err_q;

    logic                     is_idle;
    logic                     is_rsp;
    logic                     is_hold;
    logic                     slot_free;
    logic                     req_hsk;
    logic                     ld_hsk;
    logic                     in_win;
    logic [`INSTR_SIZE-1:0]   fresh_instr;
    logic [`INSTR_SIZE-1:0]   buf_data;
    logic                     buf_err;
    logic                     buf_load;
    logic                     buf_clear;
    logic                     unused_pc_lsb;

    // Instructions are word aligned; the byte offset carries no information.
    assign unused_pc_lsb = ^ifu_req_pc[1:0];

    assign state_q = itcm_state_e'(state_raw_q);
    assign is_idle = (state_q == ST_IDLE);
    assign is_rsp  = (state_q == ST_RSP);
    assign is_hold = (state_q == ST_HOLD);

    // The single response slot frees up either when empty or in the very
    // cycle the current response is taken, which gives back-to-back fetch.
    assign slot_free = is_idle | ((is_rsp | is_hold) & ifu_rsp_ready);

    // Loader owns the SRAM port whenever it asks; fetch waits it out.
    assign ld_ready      = ld_valid & slot_free;
    assign ifu_req_ready = ~ld_valid & slot_free;
    assign ld_hsk        = ld_valid & ld_ready;
    assign req_hsk       = ifu_req_valid & ifu_req_ready;

    assign in_win = (ifu_req_pc[`PC_SIZE-1:ITCM_ADDR_WIDTH] ==
                     ITCM_BASE[`PC_SIZE-1:ITCM_ADDR_WIDTH]);

    // SRAM port: out-of-window fetches never touch the macro.
    always_comb begin
        ram_cs    = ld_hsk | (req_hsk & in_win);
        ram_we    = ld_hsk;
        ram_addr  = ld_hsk ? ld_addr : ifu_req_pc[ITCM_ADDR_WIDTH-1:2];
        ram_wdata = ld_wdata;
    end

    // Error flag travels with the request into the response cycle.
    assign err_d = ~in_win;

    gnrl_dfflr #(.DW(1)) u_err_dff (
        .lden  (req_hsk),
        .dnxt  (err_d),
        .qout  (err_q),
        .clk   (clk),
        .rst_n (rst_n)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_hsk) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP, ST_HOLD: begin
                if (ifu_rsp_ready) begin
                    state_d = req_hsk ? ST_RSP : ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    gnrl_dffr #(.DW(2)) u_state_dff (
        .dnxt  (state_d),
        .qout  (state_raw_q),
        .clk   (clk),
        .rst_n (rst_n)
    );

    assign fresh_instr = err_q ? `INSTR_NOP : ram_dout;

    // The SRAM output is only valid in the RSP cycle, so a stalled response
    // is parked here rather than re-reading the macro.
    assign buf_load  = is_rsp & ~ifu_rsp_ready;
    assign buf_clear = is_hold & ifu_rsp_ready;

    ifu_itcm_rsp_buf #(.DW(`INSTR_SIZE)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .data_i  (fresh_instr),
        .err_i   (err_q),
        .data_o  (buf_data),
        .err_o   (buf_err)
    );

    always_comb begin
        ifu_rsp_valid = ~is_idle;
        ifu_rsp_instr = is_hold ? buf_data : fresh_instr;
        // err_q lingers after the response; only report it while presenting.
        ifu_rsp_err   = is_hold ? buf_err : (is_rsp & err_q);
        dbg_state     = state_raw_q;
    end
endmodule

// File: tb/tb_ifu_itcm_rsp.sv
// ---------------------------------------------------------------------------
// tb_ifu_itcm_rsp
// Directed bench for ifu_itcm_rsp with a behavioural 1-cycle SRAM model.
// Driver pushes the hand-computed {err, instr} of every accepted fetch into
// exp_q; a monitor pops and compares on each response handshake.
// ---------------------------------------------------------------------------
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module tb_ifu_itcm_rsp;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] W0   = 32'h0000_0093;
    localparam logic [31:0] W1   = 32'h0010_0113;
    localparam logic [31:0] W2   = 32'h0020_0193;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_rsp_err;
    logic        ld_valid;
    logic        ld_ready;
    logic [11:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ram_cs;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_dout;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:4095];
    logic [32:0] exp_q [$];
    int          n_checks;
    int          n_pass;

    ifu_itcm_rsp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_pc    (ifu_req_pc),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_instr (ifu_rsp_instr),
        .ifu_rsp_err   (ifu_rsp_err),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_addr       (ld_addr),
        .ld_wdata      (ld_wdata),
        .ram_cs        (ram_cs),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_dout      (ram_dout),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: output is junk in any cycle after a non-read, so a
    // responder that relies on a stale read is caught.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]   <= W0;
            mem[1]   <= W1;
            mem[2]   <= W2;
            ram_dout <= JUNK;
        end else if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_wdata;
            ram_dout      <= JUNK;
        end else if (ram_cs) begin
            ram_dout <= mem[ram_addr];
        end else begin
            ram_dout <= JUNK;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ifu_rsp_valid && ifu_rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got %h expected none", {ifu_rsp_err, ifu_rsp_instr});
            end else begin
                check("rsp_payload", {ifu_rsp_err, ifu_rsp_instr}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic rv, input logic [31:0] pc, input logic rr,
                        input logic lv, input logic [11:0] la, input logic [31:0] lw);
        @(posedge clk);
        #1;
        ifu_req_valid = rv;
        ifu_req_pc    = pc;
        ifu_rsp_ready = rr;
        ld_valid      = lv;
        ld_addr       = la;
        ld_wdata      = lw;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic rr);
        step(1'b1, pc, rr, 1'b0, 12'd0, 32'd0);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 32'd0, rr, 1'b0, 12'd0, 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_req_pc    = '0;
        ifu_rsp_ready = 1'b0;
        ld_valid      = 1'b0;
        ld_addr       = '0;
        ld_wdata      = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_rsp_valid", 33'(ifu_rsp_valid), 33'd0);
        check("rst_rsp_err",   33'(ifu_rsp_err),   33'd0);
        check("rst_state",     33'(dbg_state),     33'd0);
        check("rst_req_ready", 33'(ifu_req_ready), 33'd1);
        check("rst_ld_ready",  33'(ld_ready),      33'd0);
        check("rst_ram_cs",    33'(ram_cs),        33'd0);

        // Single fetch from word 0
        fetch(BASE, 1'b1);
        check("t1_req_ready", 33'(ifu_req_ready), 33'd1);
        check("t1_ram_cs",    33'(ram_cs),        33'd1);
        check("t1_ram_we",    33'(ram_we),        33'd0);
        check("t1_ram_addr",  33'(ram_addr),      33'd0);
        exp_q.push_back({1'b0, W0});
        idle(1'b1);
        check("t1_rsp_valid", 33'(ifu_rsp_valid), 33'd1);
        check("t1_state_rsp", 33'(dbg_state),     33'd1);

        // Back-to-back fetches
        fetch(BASE, 1'b1);
        check("t2_req_ready0", 33'(ifu_req_ready), 33'd1);
        exp_q.push_back({1'b0, W0});
        fetch(BASE + 32'd4, 1'b1);
        check("t2_req_ready1", 33'(ifu_req_ready), 33'd1);
        check("t2_rsp_valid1", 33'(ifu_rsp_valid), 33'd1);
        check("t2_ram_addr1",  33'(ram_addr),      33'd1);
        exp_q.push_back({1'b0, W1});
        fetch(BASE + 32'd8, 1'b1);
        check("t2_req_ready2", 33'(ifu_req_ready), 33'd1);
        check("t2_rsp_valid2", 33'(ifu_rsp_valid), 33'd1);
        check("t2_ram_addr2",  33'(ram_addr),      33'd2);
        exp_q.push_back({1'b0, W2});
        idle(1'b1);
        check("t2_rsp_valid3", 33'(ifu_rsp_valid), 33'd1);
        idle(1'b1);
        check("t2_rsp_drained", 33'(ifu_rsp_valid), 33'd0);
        check("t2_state_idle",  33'(dbg_state),     33'd0);

        // Stalled response: 3 cycles without rsp_ready
        fetch(BASE + 32'd4, 1'b1);
        exp_q.push_back({1'b0, W1});
        idle(1'b0);
        check("t3_state_rsp",  33'(dbg_state),     33'd1);
        check("t3_instr_rsp",  33'(ifu_rsp_instr), 33'(W1));
        for (int i = 0; i < 2; i++) begin
            fetch(BASE, 1'b0);
            check("t3_state_hold", 33'(dbg_state),     33'd2);
            check("t3_instr_hold", 33'(ifu_rsp_instr), 33'(W1));
            check("t3_err_hold",   33'(ifu_rsp_err),   33'd0);
            check("t3_req_ready",  33'(ifu_req_ready), 33'd0);
            check("t3_ram_cs",     33'(ram_cs),        33'd0);
        end
        idle(1'b1);
        check("t3_release_valid", 33'(ifu_rsp_valid), 33'd1);
        idle(1'b1);
        check("t3_state_idle", 33'(dbg_state), 33'd0);

        // Out-of-window fetch
        fetch(32'h0000_1000, 1'b1);
        check("t4_ram_cs",    33'(ram_cs),        33'd0);
        check("t4_req_ready", 33'(ifu_req_ready), 33'd1);
        exp_q.push_back({1'b1, NOP});
        idle(1'b1);
        check("t4_rsp_err",   33'(ifu_rsp_err),   33'd1);
        check("t4_rsp_instr", 33'(ifu_rsp_instr), 33'(NOP));

        // Loader beats a simultaneous fetch, then the fetch reads the new word
        step(1'b1, BASE + 32'd20, 1'b1, 1'b1, 12'd5, 32'hDEAD_BEEF);
        check("t5_ld_ready",  33'(ld_ready),      33'd1);
        check("t5_ram_we",    33'(ram_we),        33'd1);
        check("t5_ram_cs",    33'(ram_cs),        33'd1);
        check("t5_ram_addr",  33'(ram_addr),      33'd5);
        check("t5_ram_wdata", 33'(ram_wdata),     33'(32'hDEAD_BEEF));
        check("t5_req_ready", 33'(ifu_req_ready), 33'd0);
        fetch(BASE + 32'd20, 1'b1);
        check("t5_req_ready2", 33'(ifu_req_ready), 33'd1);
        check("t5_ram_rd",     33'({ram_cs, ram_we}), 33'd2);
        check("t5_ram_addr2",  33'(ram_addr),      33'd5);
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        idle(1'b1);
        check("t5_rsp_valid", 33'(ifu_rsp_valid), 33'd1);
        idle(1'b1);

        // Async reset while a response is held: dropped, never replayed
        fetch(BASE, 1'b1);
        idle(1'b0);
        idle(1'b0);
        check("t6_state_hold", 33'(dbg_state), 33'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 33'(ifu_rsp_valid), 33'd0);
        check("t6_rst_state", 33'(dbg_state),     33'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle(1'b1);
            check("t6_no_stale", 33'(ifu_rsp_valid), 33'd0);
            check("t6_state",    33'(dbg_state),     33'd0);
        end

        check("queue_empty", 33'(exp_q.size()), 33'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
